multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Finite-state sequencer that drives the RV32I datapath in multi-cycle mode. Each instruction steps through fetch, decode, execute, memory and writeback. The block handshakes with instruction and data memory and gates the PC, IR and register-file write strobes. It uses the decoded control signals from `control_unit` (registered from the IR), plus the branch comparison result, to pick the path for each instruction. It also flags bus timeouts and illegal encodings.

## Interface
- `MEM_TIMEOUT`, 16: max cycles a memory request waits for ready before faulting (≥1)
- `CNT_W`, 32: width of retired-instruction counter

- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `run` in 1: enable; sampled at instruction boundaries
- `imem_ready` in 1: instruction memory data valid
- `dmem_ready` in 1: data memory access complete
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump` in 1 each: decoded controls, stable from DECODE until retire
- `illegal_instr` in 1: decoder flagged unsupported opcode
- `branch_taken` in 1: ALU branch compare result, valid in EXECUTE
- `imem_req` out 1: instruction fetch request
- `ir_we` out 1: IR load strobe
- `dmem_req` out 1: data memory request
- `dmem_we` out 1: data memory write (store)
- `rf_we` out 1: register-file write strobe
- `pc_we` out 1: PC update strobe
- `pc_sel` out 1: 0 = PC+4, 1 = branch/jump target
- `retire` out 1: one-cycle pulse per completed instruction
- `state` out 3: current state encoding
- `fault` out 1: sticky fault flag
- `fault_code` out 2: 01 fetch timeout, 10 illegal, 11 data timeout
- `instret` out CNT_W: retired-instruction count

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, FAULT=6. Codes 7 and up → FAULT, code 10.
- IDLE: all strobes 0. `run`=1 → FETCH.
- FETCH: `imem_req`=1.
  - When `imem_ready`=1: `ir_we`=1 in that cycle, then → DECODE.
  - Timeout → FAULT, code 01.
- DECODE: one cycle. Go to FAULT, code 10, if `illegal_instr`=1, or if `mem_read` and `mem_write` are both 1. Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - If `mem_read` or `mem_write` → MEM.
  - Else if `branch`: `pc_we`=1, `pc_sel`=`branch_taken`, `retire`=1, then → FETCH if `run` else IDLE.
  - Else → WB.
- MEM: `dmem_req`=1, `dmem_we`=`mem_write`.
  - On `dmem_ready`=1 with a store: `pc_we`=1, `pc_sel`=0, `retire`=1, then → FETCH/IDLE.
  - On `dmem_ready`=1 with a load → WB.
  - Timeout → FAULT, code 11.
- WB: one cycle. `rf_we`=`reg_write`, `pc_we`=1, `pc_sel`=`jump`, `retire`=1, then → FETCH if `run` else IDLE.
- FAULT: all strobes 0, `fault`=1, `fault_code` held. Exits only via `rst`.
- `instret` increments on every `retire` and wraps from 2^CNT_W−1 to 0.
- `run` deasserted mid-instruction: the current instruction completes and retires, then → IDLE.

## Timing
- Reset (async, immediate): `state`=IDLE, `fault`=0, `fault_code`=00, `instret`=0, timeout counter 0, all strobes 0.
- Registered: `state`, `fault`, `fault_code`, `instret`, timeout counter.
- Combinational: strobes, decoded from `state` plus current inputs. `ir_we` and the MEM completion actions are combinational on same-cycle ready.
- Timeout counter: cleared on entry to FETCH or MEM, increments each waiting cycle.
  - Ready high in wait cycle k (k=1..MEM_TIMEOUT) is accepted.
  - Ready still low in cycle MEM_TIMEOUT → FAULT on the next edge.
  - Ready in the last cycle wins over timeout.
- Latency with zero-wait memory, counted FETCH through retire:
  - ALU op or JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Back-to-back: with `run`=1, FETCH follows the retire cycle with no bubble.
- Async reset mid-request drops `imem_req`/`dmem_req` in the same cycle.

## Test plan
- Reset, then `run`=1, ADD decode (`reg_write`=1), ready always 1 → states 1,2,3,5. `ir_we` in cycle 1, `rf_we`+`pc_we`+`retire` in cycle 4, `pc_sel`=0, `instret`=1.
- Load with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, WB follows, `retire` in cycle 8, `rf_we`=1.
- BEQ with `branch_taken`=1, then BNE with `branch_taken`=0 → retire in EXECUTE, `pc_sel`=1 then 0, `rf_we` never 1.
- MEM_TIMEOUT=16, `imem_ready` held 0 → FAULT after 16 request cycles, `fault_code`=01, strobes 0. Separately, ready in cycle 16 is accepted with no fault.
- `illegal_instr`=1 in DECODE → FAULT, code 10. Same code when `mem_read`=`mem_write`=1. Both faults persist until `rst`.
- CNT_W=4: retire 17 instructions → `instret`=1. Drop `run` during MEM → store completes, then IDLE. Assert `rst` mid-FETCH → IDLE and all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FSM stepping RV32I instructions through fetch/decode/execute/mem/writeback
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             illegal_instr,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic [2:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3;
  localparam logic [2:0] MEM = 3'd4, WB = 3'd5, FAULT = 3'd6;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [2:0] nxt, done_nxt;
  logic [1:0] nxt_code;
  logic [TW-1:0] tcnt;
  logic tmo, mem_op, ex_br;
  assign tmo = tcnt == TW'(MEM_TIMEOUT - 1);
  assign mem_op = mem_read | mem_write;
  assign done_nxt = run ? FETCH : IDLE;
  assign ex_br = state == EXECUTE && !mem_op && branch;
  assign imem_req = state == FETCH;
  assign ir_we = imem_req && imem_ready;
  assign dmem_req = state == MEM;
  assign dmem_we = dmem_req && mem_write;
  assign rf_we = state == WB && reg_write;
  assign retire = ex_br || (dmem_we && dmem_ready) || state == WB;
  assign pc_we = retire;
  assign pc_sel = (ex_br && branch_taken) || (state == WB && jump);
  // Next-state selection; ready in the final wait cycle takes priority over timeout
  always_comb begin
    nxt = state;
    nxt_code = fault_code;
    case (state)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: begin
        nxt = imem_ready ? DECODE : tmo ? FAULT : FETCH;
        nxt_code = !imem_ready && tmo ? 2'b01 : fault_code;
      end
      DECODE: begin
        nxt = illegal_instr || (mem_read && mem_write) ? FAULT : EXECUTE;
        nxt_code = illegal_instr || (mem_read && mem_write) ? 2'b10 : fault_code;
      end
      EXECUTE: nxt = mem_op ? MEM : branch ? done_nxt : WB;
      MEM: begin
        nxt = dmem_ready ? (mem_write ? done_nxt : WB) : tmo ? FAULT : MEM;
        nxt_code = !dmem_ready && tmo ? 2'b11 : fault_code;
      end
      WB: nxt = done_nxt;
      FAULT: nxt = FAULT;
      default: begin
        nxt = FAULT;
        nxt_code = 2'b10;
      end
    endcase
  end
  // State, sticky fault, wait counter and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fault <= 1'b0;
      fault_code <= 2'b00;
      tcnt <= '0;
      instret <= '0;
    end else begin
      state <= nxt;
      fault <= nxt == FAULT;
      fault_code <= nxt_code;
      tcnt <= (imem_req && !imem_ready) || (dmem_req && !dmem_ready) ? tcnt + 1'b1 : '0;
      instret <= retire ? instret + 1'b1 : instret;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed scenario tests for the multi-cycle sequencer
module tb_multicycle_sequencer;
  logic clk = 0, rst = 1, run = 0, imem_ready = 0, dmem_ready = 0;
  logic reg_write = 0, mem_read = 0, mem_write = 0, branch = 0, jump = 0;
  logic illegal_instr = 0, branch_taken = 0;
  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, fault;
  logic [2:0] state;
  logic [1:0] fault_code;
  logic [3:0] instret;
  int errors = 0, checks = 0, exp_ret = 0;
  multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .illegal_instr(illegal_instr), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .state(state),
    .fault(fault), .fault_code(fault_code), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic clear_in;
    run = 0; imem_ready = 0; dmem_ready = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    branch = 0; jump = 0; illegal_instr = 0; branch_taken = 0;
  endtask
  task automatic pulse_reset;
    rst = 1;
    #1;
    rst = 0;
    exp_ret = 0;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({fault, fault_code} !== 3'b000) begin errors++; $display("FAIL reset_fault got=%b exp=000", {fault, fault_code}); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if ({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire} !== 7'd0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire}); end
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask
  task automatic test_alu;
    clear_in; reg_write = 1; imem_ready = 1; dmem_ready = 1; run = 1;
    tick;
    checks++; if ({state, imem_req, ir_we} !== {3'd1, 2'b11}) begin errors++; $display("FAIL alu_fetch got=%b exp=00111", {state, imem_req, ir_we}); end
    tick;
    checks++; if ({state, rf_we, retire} !== {3'd2, 2'b00}) begin errors++; $display("FAIL alu_decode got=%b exp=01000", {state, rf_we, retire}); end
    tick;
    checks++; if ({state, retire} !== {3'd3, 1'b0}) begin errors++; $display("FAIL alu_execute got=%b exp=0110", {state, retire}); end
    tick;
    checks++; if ({state, rf_we, pc_we, retire, pc_sel} !== {3'd5, 4'b1110}) begin errors++; $display("FAIL alu_wb got=%b exp=1011110", {state, rf_we, pc_we, retire, pc_sel}); end
    run = 0;
    tick; exp_ret++;
    checks++; if ({state, instret} !== {3'd0, 4'd1}) begin errors++; $display("FAIL alu_retire got=%0d/%0d exp=0/1", state, instret); end
  endtask
  task automatic test_load;
    int reqs;
    clear_in; mem_read = 1; reg_write = 1; imem_ready = 1; run = 1;
    reqs = 0;
    repeat (4) tick;
    checks++; if ({state, dmem_req, dmem_we} !== {3'd4, 2'b10}) begin errors++; $display("FAIL load_mem got=%b exp=10010", {state, dmem_req, dmem_we}); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin dmem_ready = 1; #1; end
      reqs += int'(dmem_req);
      if (k < 3) tick;
    end
    checks++; if (reqs !== 4 || retire !== 1'b0) begin errors++; $display("FAIL load_req_cycles got=%0d retire=%b exp=4 retire=0", reqs, retire); end
    tick;
    checks++; if ({state, rf_we, pc_we, retire, dmem_req} !== {3'd5, 4'b1110}) begin errors++; $display("FAIL load_wb got=%b exp=1011110", {state, rf_we, pc_we, retire, dmem_req}); end
    run = 0; dmem_ready = 0;
    tick; exp_ret++;
    checks++; if ({state, instret} !== {3'd0, 4'(exp_ret)}) begin errors++; $display("FAIL load_retire got=%0d/%0d exp=0/%0d", state, instret, exp_ret); end
  endtask
  task automatic test_branch;
    int rf_seen;
    clear_in; branch = 1; branch_taken = 1; imem_ready = 1; run = 1;
    rf_seen = 0;
    repeat (3) begin tick; rf_seen += int'(rf_we); end
    checks++; if ({state, pc_we, pc_sel, retire} !== {3'd3, 3'b111}) begin errors++; $display("FAIL beq_exec got=%b exp=011111", {state, pc_we, pc_sel, retire}); end
    tick; exp_ret++;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL beq_next_fetch got=%0d exp=1", state); end
    branch_taken = 0;
    repeat (2) begin tick; rf_seen += int'(rf_we); end
    checks++; if ({state, pc_we, pc_sel, retire} !== {3'd3, 3'b101}) begin errors++; $display("FAIL bne_exec got=%b exp=011101", {state, pc_we, pc_sel, retire}); end
    run = 0;
    tick; exp_ret++;
    checks++; if ({state, instret, rf_seen[3:0]} !== {3'd0, 4'(exp_ret), 4'd0}) begin errors++; $display("FAIL branch_end got=%0d/%0d rf=%0d exp=0/%0d rf=0", state, instret, rf_seen, exp_ret); end
  endtask
  task automatic test_fetch_last_cycle;
    clear_in; reg_write = 1; run = 1;
    tick;
    repeat (15) tick;
    checks++; if ({state, ir_we} !== {3'd1, 1'b0}) begin errors++; $display("FAIL fetch16_wait got=%b exp=0010", {state, ir_we}); end
    imem_ready = 1; #1;
    checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL fetch16_irwe got=%b exp=1", ir_we); end
    tick;
    checks++; if ({state, fault} !== {3'd2, 1'b0}) begin errors++; $display("FAIL fetch16_accept got=%b exp=0100", {state, fault}); end
    run = 0;
    repeat (3) tick; exp_ret++;
    checks++; if ({state, instret} !== {3'd0, 4'(exp_ret)}) begin errors++; $display("FAIL fetch16_retire got=%0d/%0d exp=0/%0d", state, instret, exp_ret); end
  endtask
  task automatic test_store_run_drop;
    clear_in; mem_write = 1; imem_ready = 1; run = 1;
    repeat (4) tick;
    checks++; if ({state, dmem_req, dmem_we, retire} !== {3'd4, 3'b110}) begin errors++; $display("FAIL store_mem got=%b exp=100110", {state, dmem_req, dmem_we, retire}); end
    run = 0;
    tick;
    dmem_ready = 1; #1;
    checks++; if ({retire, pc_we, pc_sel, rf_we} !== 4'b1100) begin errors++; $display("FAIL store_done got=%b exp=1100", {retire, pc_we, pc_sel, rf_we}); end
    tick; exp_ret++;
    checks++; if ({state, instret} !== {3'd0, 4'(exp_ret)}) begin errors++; $display("FAIL store_idle got=%0d/%0d exp=0/%0d", state, instret, exp_ret); end
  endtask
  task automatic test_back_to_back_wrap;
    int bad;
    clear_in; branch = 1; imem_ready = 1; run = 1;
    bad = 0;
    while (exp_ret < 17) begin
      tick;
      if (state !== 3'd1) bad++;
      repeat (2) tick;
      if (retire !== 1'b1 || state !== 3'd3) bad++;
      exp_ret++;
      if (exp_ret == 17) run = 0;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_sequence got=%0d bad cycles exp=0", bad); end
    tick;
    checks++; if ({state, instret} !== {3'd0, 4'd1}) begin errors++; $display("FAIL instret_wrap got=%0d/%0d exp=0/1", state, instret); end
  endtask
  task automatic test_reset_mid_fetch;
    clear_in; run = 1;
    tick;
    checks++; if ({state, imem_req} !== {3'd1, 1'b1}) begin errors++; $display("FAIL midfetch_req got=%b exp=0011", {state, imem_req}); end
    rst = 1; run = 0; #1;
    checks++; if ({state, imem_req, fault, instret} !== 8'd0) begin errors++; $display("FAIL midfetch_reset got=%b exp=0", {state, imem_req, fault, instret}); end
    rst = 0; exp_ret = 0;
  endtask
  task automatic test_fetch_timeout;
    clear_in; run = 1;
    tick;
    repeat (15) tick;
    checks++; if ({state, fault} !== {3'd1, 1'b0}) begin errors++; $display("FAIL ftmo_wait got=%b exp=0010", {state, fault}); end
    run = 0;
    tick;
    checks++; if ({state, fault, fault_code, imem_req, ir_we, pc_we, retire} !== {3'd6, 3'b101, 4'd0}) begin errors++; $display("FAIL ftmo_fault got=%b exp=11010100000", {state, fault, fault_code, imem_req, ir_we, pc_we, retire}); end
    pulse_reset;
  endtask
  task automatic test_data_timeout;
    clear_in; mem_read = 1; imem_ready = 1; run = 1;
    repeat (4) tick;
    run = 0;
    repeat (15) tick;
    checks++; if ({state, dmem_req} !== {3'd4, 1'b1}) begin errors++; $display("FAIL dtmo_wait got=%b exp=1001", {state, dmem_req}); end
    tick;
    checks++; if ({state, fault, fault_code, dmem_req} !== {3'd6, 4'b1110}) begin errors++; $display("FAIL dtmo_fault got=%b exp=1101110", {state, fault, fault_code, dmem_req}); end
    pulse_reset;
  endtask
  task automatic test_illegal;
    clear_in; illegal_instr = 1; imem_ready = 1; run = 1;
    repeat (3) tick;
    checks++; if ({state, fault, fault_code} !== {3'd6, 3'b110}) begin errors++; $display("FAIL illegal_fault got=%b exp=110110", {state, fault, fault_code}); end
    clear_in; run = 1; imem_ready = 1;
    repeat (4) tick;
    checks++; if ({state, fault, fault_code, imem_req} !== {3'd6, 4'b1100}) begin errors++; $display("FAIL illegal_sticky got=%b exp=1101100", {state, fault, fault_code, imem_req}); end
    pulse_reset;
    clear_in; mem_read = 1; mem_write = 1; imem_ready = 1; run = 1;
    repeat (3) tick;
    checks++; if ({state, fault, fault_code, dmem_req} !== {3'd6, 4'b1100}) begin errors++; $display("FAIL rw_fault got=%b exp=1101100", {state, fault, fault_code, dmem_req}); end
    run = 0;
    repeat (3) tick;
    checks++; if ({state, fault_code} !== {3'd6, 2'b10}) begin errors++; $display("FAIL rw_sticky got=%b exp=11010", {state, fault_code}); end
    pulse_reset;
    #1;
    checks++; if ({state, fault, fault_code} !== 6'd0) begin errors++; $display("FAIL fault_clear got=%b exp=0", {state, fault, fault_code}); end
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_branch;
    test_fetch_last_cycle;
    test_store_run_drop;
    test_back_to_back_wrap;
    test_reset_mid_fetch;
    test_fetch_timeout;
    test_data_timeout;
    test_illegal;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
